// File: rtl/proc_run_ctrl_pkg.sv
// Shared encodings for the processor run-control unit: FSM states, halt causes
// and the RUN-cycle halt priority resolver.
package proc_run_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int CAUSE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_HOLD = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_HALTED     = 3'd4
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_HOST  = 3'd1,
    CAUSE_BREAK = 3'd2,
    CAUSE_LIMIT = 3'd3,
    CAUSE_STEP  = 3'd4
  } cause_t;

  // Host halt beats a breakpoint, which beats the cycle budget.
  function automatic cause_t run_halt_cause(input logic halt, input logic hit, input logic limit);
    cause_t c;
    if (halt) begin
      c = CAUSE_HOST;
    end else if (hit) begin
      c = CAUSE_BREAK;
    end else if (limit) begin
      c = CAUSE_LIMIT;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Host-side bundle of the run-control unit: requests, breakpoint/budget
// configuration, processor PC in, and the control/status outputs.
interface proc_run_ctrl_if
  import proc_run_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
);

  logic                     run_req;
  logic                     step_req;
  logic                     halt_req;
  logic                     restart_req;
  logic [ADDR_W-1:0]        pc_in;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic [CNT_W-1:0]         max_cycles;

  logic                     proc_rst;
  logic                     proc_en;
  logic [STATE_W-1:0]       state;
  logic                     halted;
  logic [CAUSE_W-1:0]       halt_cause;
  logic                     step_done;
  logic [CNT_W-1:0]         cycle_cnt;

  modport master (
    output run_req, step_req, halt_req, restart_req,
    output pc_in, bp_addr, bp_en, max_cycles,
    input  proc_rst, proc_en, state, halted, halt_cause, step_done, cycle_cnt
  );

  modport slave (
    input  run_req, step_req, halt_req, restart_req,
    input  pc_in, bp_addr, bp_en, max_cycles,
    output proc_rst, proc_en, state, halted, halt_cause, step_done, cycle_cnt
  );

endinterface

// File: rtl/proc_run_ctrl_bp_match.sv
// Combinational PC breakpoint comparator bank; a set mask suppresses every hit
// (used to step over the breakpoint the processor is resuming from).
module bp_match #(
  parameter int NUM_BP = 2,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic                     mask,
  output logic                     hit
);

  logic hit_raw_s;

  // OR-reduce all enabled comparators, then apply the resume mask.
  always_comb begin
    hit_raw_s = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_raw_s = hit_raw_s | (bp_en[i] & (pc_in == bp_addr[i*ADDR_W +: ADDR_W]));
    end
    hit = hit_raw_s & ~mask;
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run-control unit for the processor: reset stretching, clock-enable gating,
// run/halt/single-step/restart, PC breakpoints and a cycle budget.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int NUM_BP     = 2
) (
  input logic           clk,
  input logic           rst,
  proc_run_ctrl_if.slave bus
);

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  cause_t            cause_r;
  cause_t            cause_s;
  cause_t            run_cause_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic [CNT_W-1:0]  cycle_cnt_r;
  logic              bp_skip_r;
  logic              bp_skip_s;
  logic              proc_rst_r;
  logic              halted_r;
  logic              step_done_r;
  logic              step_done_s;
  logic              proc_en_s;
  logic              clr_cnt_s;
  logic              hit_s;
  logic              limit_s;

  bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .pc_in   (bus.pc_in),
    .bp_addr (bus.bp_addr),
    .bp_en   (bus.bp_en),
    .mask    (bp_skip_r),
    .hit     (hit_s)
  );

  // Halt decision for a RUN cycle; only consumed while state_r is ST_RUN.
  always_comb begin
    limit_s     = (bus.max_cycles != CNT_ZERO) && (cycle_cnt_r >= bus.max_cycles);
    run_cause_s = run_halt_cause(bus.halt_req, hit_s, limit_s);
  end

  // Processor clock-enable: a halting RUN cycle is not executed; STEP always executes.
  always_comb begin
    proc_en_s = 1'b0;
    case (state_r)
      ST_RUN:  proc_en_s = (run_cause_s == CAUSE_NONE);
      ST_STEP: proc_en_s = 1'b1;
      default: proc_en_s = 1'b0;
    endcase
  end

  // Next-state logic: restart > halt > step > run.
  always_comb begin
    state_s     = state_r;
    cause_s     = cause_r;
    hold_cnt_s  = hold_cnt_r;
    bp_skip_s   = bp_skip_r;
    step_done_s = 1'b0;
    clr_cnt_s   = 1'b0;
    if (bus.restart_req) begin
      state_s    = ST_RESET_HOLD;
      cause_s    = CAUSE_NONE;
      hold_cnt_s = {HOLD_W{1'b0}};
      bp_skip_s  = 1'b0;
      clr_cnt_s  = 1'b1;
    end else begin
      case (state_r)
        ST_RESET_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_s = ST_IDLE;
          end else begin
            hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE, ST_HALTED: begin
          if (bus.halt_req) begin
            // A host halt while already halted keeps the original cause.
            if (state_r == ST_IDLE) begin
              state_s = ST_HALTED;
              cause_s = CAUSE_HOST;
            end else begin
              state_s = state_r;
            end
          end else if (bus.step_req || bus.run_req) begin
            state_s = bus.step_req ? ST_STEP : ST_RUN;
            // Resuming from a halt must execute the PC it stopped on once.
            if (state_r == ST_HALTED) begin
              cause_s   = CAUSE_NONE;
              bp_skip_s = 1'b1;
            end else begin
              bp_skip_s = bp_skip_r;
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_RUN: begin
          bp_skip_s = 1'b0;
          if (run_cause_s != CAUSE_NONE) begin
            state_s = ST_HALTED;
            cause_s = run_cause_s;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_STEP: begin
          state_s     = ST_HALTED;
          cause_s     = CAUSE_STEP;
          step_done_s = 1'b1;
        end
        default: begin
          state_s    = ST_RESET_HOLD;
          cause_s    = CAUSE_NONE;
          hold_cnt_s = {HOLD_W{1'b0}};
          clr_cnt_s  = 1'b1;
        end
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RESET_HOLD;
      cause_r     <= CAUSE_NONE;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      bp_skip_r   <= 1'b0;
      step_done_r <= 1'b0;
      proc_rst_r  <= 1'b1;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cause_r     <= cause_s;
      hold_cnt_r  <= hold_cnt_s;
      bp_skip_r   <= bp_skip_s;
      step_done_r <= step_done_s;
      proc_rst_r  <= (state_s == ST_RESET_HOLD);
      halted_r    <= (state_s == ST_HALTED);
    end
  end

  // Enabled-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r <= CNT_ZERO;
    end else if (clr_cnt_s) begin
      cycle_cnt_r <= CNT_ZERO;
    end else if (proc_en_s && (cycle_cnt_r != CNT_MAX)) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign bus.proc_rst   = proc_rst_r;
  assign bus.proc_en    = proc_en_s;
  assign bus.state      = state_r;
  assign bus.halted     = halted_r;
  assign bus.halt_cause = cause_r;
  assign bus.step_done  = step_done_r;
  assign bus.cycle_cnt  = cycle_cnt_r;

endmodule
